// File: rtl/silife_wb_host.sv
// silife_wb_host
// Turns a simple valid/ready command stream into single-beat classic
// Wishbone cycles. It returns one response per command on a valid/ready
// response stream.
//
// Parameters
//   BASE_ADDR       upper address byte, driven on o_wb_addr[31:24]
//   TIMEOUT_CYCLES  maximum number of BUS cycles spent waiting for ack (2..255)
//
// Optional feature (macro SILIFE_WB_HOST_TIMEOUT_EN)
//   defined   : a bus timeout counter ends a stalled cycle with o_rsp_err = 1
//   undefined : BUS waits for ack forever, and o_rsp_err is tied to 0
//
// Ports
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   i_cmd_valid / o_cmd_ready   command handshake
//   i_cmd_we, i_cmd_addr,
//   i_cmd_data                  command: direction, 24-bit offset, write data
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_data, o_rsp_err       read data (0 for writes/errors), timeout flag
//   o_wb_*, i_wb_*              Wishbone initiator
//   o_busy                      high whenever the FSM is not IDLE
module silife_wb_host #(
    parameter logic [7:0] BASE_ADDR      = 8'h30,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [23:0] i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic [31:0] r_rsp_data;

    logic        w_accept;
    logic        w_ack;
    logic        w_expire;

    assign w_accept = i_cmd_valid && (r_state == S_IDLE);
    // An ack outside BUS is ignored.
    assign w_ack    = i_wb_ack && (r_state == S_BUS);

`ifdef SILIFE_WB_HOST_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_rsp_err;

    // The counter is held at zero outside BUS, so it is already clear
    // on entry. The check against TMO_LAST happens on the edge that would
    // otherwise increment past it. BUS therefore lasts exactly
    // TIMEOUT_CYCLES cycles when no ack arrives.
    always_ff @(posedge clk) begin
        if (reset || r_state != S_BUS)
            r_tmo_cnt <= 8'd0;
        else if (!i_wb_ack)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end

    // If an ack arrives on the expiry edge, the ack wins.
    assign w_expire = (r_state == S_BUS) && !i_wb_ack && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset)
            r_rsp_err <= 1'b0;
        else if (w_ack)
            r_rsp_err <= 1'b0;
        else if (w_expire)
            r_rsp_err <= 1'b1;
    end

    assign o_rsp_err = r_rsp_err;
`else
    assign w_expire  = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_cmd_valid)          w_state_nxt = S_BUS;
            S_BUS:  if (i_wb_ack || w_expire) w_state_nxt = S_RESP;
            S_RESP: if (i_rsp_ready)          w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    // Command capture and response data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_wb_addr  <= 32'd0;
            r_wb_data  <= 32'd0;
            r_rsp_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we      <= i_cmd_we;
                r_wb_addr <= {BASE_ADDR, i_cmd_addr};
                r_wb_data <= i_cmd_data;
            end
            if (w_ack)
                r_rsp_data <= r_we ? 32'd0 : i_wb_data;
            else if (w_expire)
                r_rsp_data <= 32'd0;
        end
    end

    // cyc and stb are decoded straight from the state. They therefore rise
    // on the accept edge, fall on the ack/expiry/reset edge, and always match.
    assign o_wb_cyc    = (r_state == S_BUS);
    assign o_wb_stb    = (r_state == S_BUS);
    assign o_wb_we     = r_we;
    assign o_wb_addr   = r_wb_addr;
    assign o_wb_data   = r_wb_data;
    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != S_IDLE);

endmodule
